demux1to5_32_buf: RTL

//  Distributes one 32-bit result stream to five destination lanes, selected by a 3-bit code.

---
 rtl/demux1to5_32_buf.sv | 129 ++++++++++++
 1 files changed

// File: rtl/demux1to5_32_buf.sv
// demux1to5_32_buf
// Routes one result stream to five one-entry holding lanes chosen by a 3-bit
// select code. Each lane has a valid/ack handshake, so a slow consumer stalls
// the source through in_ready. Codes 5..7 name no lane: those transfers are
// always accepted, then discarded, flagged in err_sel and counted in drop_cnt.
module demux1to5_32_buf #(
   parameter int WIDTH      = 32,
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [2:0]            in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out0,
   output logic [WIDTH-1:0]      out1,
   output logic [WIDTH-1:0]      out2,
   output logic [WIDTH-1:0]      out3,
   output logic [WIDTH-1:0]      out4,
   output logic [4:0]            out_valid,
   input  logic [4:0]            out_ack,
   output logic                  err_sel,
   input  logic                  err_clr,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int NUM_LANES = 5;

   // Per-lane occupancy: EMPTY means the lane may be written freely.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } lane_state_t;

   logic                  xfer;
   logic                  illegal_xfer;
   logic [NUM_LANES-1:0]  lane_full;
   logic [WIDTH-1:0]      lane_data [NUM_LANES];
   logic                  err_sel_reg;
   logic [DROP_CNT_W-1:0] drop_cnt_reg;

   // Ready depends only on the selected lane's occupancy and its ack, never on
   // in_valid, so the source can look at in_ready before committing.
   always_comb begin
      in_ready = 1'b1;
      case (in_sel)
         3'd0:    in_ready = ~lane_full[0] | out_ack[0];
         3'd1:    in_ready = ~lane_full[1] | out_ack[1];
         3'd2:    in_ready = ~lane_full[2] | out_ack[2];
         3'd3:    in_ready = ~lane_full[3] | out_ack[3];
         3'd4:    in_ready = ~lane_full[4] | out_ack[4];
         default: in_ready = 1'b1;
      endcase
   end

   assign xfer         = in_valid & in_ready;
   assign illegal_xfer = xfer & (in_sel > 3'd4);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         lane_state_t      state_reg;
         lane_state_t      state_next;
         logic [WIDTH-1:0] data_reg;
         logic             wr;
         logic             ack;

         assign wr  = xfer & (in_sel == 3'(gi));
         assign ack = out_ack[gi];

         // Lane occupancy register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_reg <= EMPTY;
            else        state_reg <= state_next;
         end

         // A write always leaves the lane full (a same-cycle ack just retires
         // the old word); an ack alone empties it; an ack on an empty lane
         // does nothing.
         always_comb begin
            state_next = state_reg;
            if (state_reg == EMPTY) begin
               if (wr) state_next = FULL;
            end else begin
               if (ack && !wr) state_next = EMPTY;
            end
         end

         // Holding register: loads on a write, otherwise keeps its last word
         // even after the lane has been consumed.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  data_reg <= '0;
            else if (wr) data_reg <= in_data;
         end

         assign lane_full[gi] = (state_reg == FULL);
         assign lane_data[gi] = data_reg;
      end
   endgenerate

   // Sticky illegal-select flag and saturating drop counter; a concurrent
   // illegal transfer takes precedence over err_clr and restarts the count at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sel_reg  <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (illegal_xfer) begin
         err_sel_reg <= 1'b1;
         if (err_clr)
            drop_cnt_reg <= {{(DROP_CNT_W-1){1'b0}}, 1'b1};
         else if (drop_cnt_reg != {DROP_CNT_W{1'b1}})
            drop_cnt_reg <= drop_cnt_reg + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end else if (err_clr) begin
         err_sel_reg  <= 1'b0;
         drop_cnt_reg <= '0;
      end
   end

   assign out0      = lane_data[0];
   assign out1      = lane_data[1];
   assign out2      = lane_data[2];
   assign out3      = lane_data[3];
   assign out4      = lane_data[4];
   assign out_valid = lane_full;
   assign err_sel   = err_sel_reg;
   assign drop_cnt  = drop_cnt_reg;

endmodule
